// File: rtl/gp_axis_dbuf_interface.sv
// Ping-pong AXI-Stream input buffer and single-bank output buffer between the DMA and a CNN layer core.
// Latency: a frame is offered to the core (axisif_start) two cycles after its closing beat; results stream out one cycle after axisif_done.
// Backpressure: s_ready drops only while the bank being filled is still owned by the core; m_data/m_last hold while m_ready is low.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   s_data/s_valid/s_last/s_ready   input stream, frames delimited by s_last
//   m_data/m_valid/m_last/m_ready   result stream, cfg_out_len beats per frame
//   cfg_out_len                 result beats per frame (0 or above OUT_DATA_NUM means OUT_DATA_NUM)
//   axisif_start/axisif_done    core handshake; axisif_frame_len is the processed frame's length
//   axisif_bufferIn_*           core read port of the bank being processed
//   axisif_bufferOut_*          core write port of the output buffer
//   err_short/err_long          one-cycle frame length error pulses
// Optional: define GPAXIS_ERR_CNT_EN to add 16-bit saturating counters err_cnt_short/err_cnt_long.
module gp_axis_dbuf_interface #(
   parameter int DATA_WIDTH   = 32,
   parameter int IN_DATA_NUM  = 784,
   parameter int OUT_DATA_NUM = 10
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [DATA_WIDTH-1:0]                  s_data,
   input  logic                                   s_valid,
   input  logic                                   s_last,
   output logic                                   s_ready,
   output logic [DATA_WIDTH-1:0]                  m_data,
   output logic                                   m_valid,
   output logic                                   m_last,
   input  logic                                   m_ready,
   input  logic [$clog2(OUT_DATA_NUM+1)-1:0]      cfg_out_len,
   output logic                                   axisif_start,
   input  logic                                   axisif_done,
   output logic [$clog2(IN_DATA_NUM+1)-1:0]       axisif_frame_len,
   input  logic [$clog2(IN_DATA_NUM)-1:0]         axisif_bufferIn_adr,
   output logic [DATA_WIDTH-1:0]                  axisif_bufferIn_data,
   input  logic [$clog2(OUT_DATA_NUM)-1:0]        axisif_bufferOut_adr,
   input  logic [DATA_WIDTH-1:0]                  axisif_bufferOut_data,
   input  logic                                   axisif_bufferOut_wr,
   output logic                                   err_short,
   output logic                                   err_long
`ifdef GPAXIS_ERR_CNT_EN
   ,
   output logic [15:0]                            err_cnt_short,
   output logic [15:0]                            err_cnt_long
`endif
);

   localparam int IW  = $clog2(IN_DATA_NUM+1);
   localparam int AW  = $clog2(IN_DATA_NUM);
   localparam int OLW = $clog2(OUT_DATA_NUM+1);
   localparam int OAW = $clog2(OUT_DATA_NUM);

   typedef enum logic [1:0] {RX_FILL, RX_WAIT, RX_DROP} rx_state_t;
   typedef enum logic [1:0] {C_IDLE, C_START, C_BUSY, C_TX} c_state_t;

   logic [DATA_WIDTH-1:0] in_mem [2][IN_DATA_NUM];
   logic [DATA_WIDTH-1:0] out_mem [OUT_DATA_NUM];

   rx_state_t          rx_st;
   c_state_t           c_st;
   logic               run;        // holds s_ready low through reset and the first cycle after it
   logic               wr_bank;
   logic               rd_bank;
   logic [1:0]         full;
   logic [IW-1:0]      bank_len [2];
   logic [AW-1:0]      wcnt;
   logic [OAW-1:0]     ocnt;
   logic [OLW-1:0]     olen;

   logic hs_in, at_max, close, rel, tx_last, next_full, cur_full;

   assign hs_in   = s_valid & s_ready;
   assign at_max  = (wcnt == AW'(IN_DATA_NUM-1));
   assign close   = (rx_st == RX_FILL) & hs_in & (s_last | at_max);
   assign tx_last = (OLW'(ocnt) == olen - OLW'(1));
   assign rel     = (c_st == C_TX) & m_ready & tx_last;

   // A bank released by the core in this same cycle counts as empty, so the
   // slave side does not lose a cycle in RX_WAIT when close and release coincide.
   assign next_full = full[~wr_bank] & ~(rel & (rd_bank == ~wr_bank));
   assign cur_full  = full[wr_bank]  & ~(rel & (rd_bank == wr_bank));

   assign s_ready = run & (((rx_st == RX_FILL) & ~full[wr_bank]) | (rx_st == RX_DROP));

   assign m_data  = m_valid ? out_mem[ocnt] : '0;
   assign m_last  = m_valid & tx_last;
   assign axisif_bufferIn_data = (c_st != C_IDLE) ? in_mem[rd_bank][axisif_bufferIn_adr] : '0;

   // Buffer storage is never reset.
   always_ff @(posedge clk) begin
      if ((rx_st == RX_FILL) && hs_in)
         in_mem[wr_bank][wcnt] <= s_data;
      if ((c_st == C_BUSY) && axisif_bufferOut_wr)
         out_mem[axisif_bufferOut_adr] <= axisif_bufferOut_data;
   end

   // Receive side
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_st       <= RX_FILL;
         run         <= 1'b0;
         wr_bank     <= 1'b0;
         wcnt        <= '0;
         bank_len[0] <= '0;
         bank_len[1] <= '0;
         err_short   <= 1'b0;
         err_long    <= 1'b0;
      end else begin
         run       <= 1'b1;
         err_short <= 1'b0;
         err_long  <= 1'b0;
         case (rx_st)
            RX_FILL: begin
               if (hs_in) begin
                  if (s_last || at_max) begin
                     bank_len[wr_bank] <= IW'(wcnt) + IW'(1);
                     wr_bank   <= ~wr_bank;
                     wcnt      <= '0;
                     err_short <= s_last & ~at_max;
                     err_long  <= ~s_last;
                     if (!s_last)
                        rx_st <= RX_DROP;
                     else if (next_full)
                        rx_st <= RX_WAIT;
                  end else begin
                     wcnt <= wcnt + 1'b1;
                  end
               end
            end
            RX_WAIT: begin
               if (!full[wr_bank])
                  rx_st <= RX_FILL;
            end
            RX_DROP: begin
               // wr_bank already points at the next bank while the overflow tail is discarded
               if (hs_in && s_last)
                  rx_st <= cur_full ? RX_WAIT : RX_FILL;
            end
            default: rx_st <= RX_FILL;
         endcase
      end
   end

   // Bank ownership: close and release always target different banks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 2'b00;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (close && (wr_bank == 1'(b)))
               full[b] <= 1'b1;
            else if (rel && (rd_bank == 1'(b)))
               full[b] <= 1'b0;
         end
      end
   end

   // Core side
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_st             <= C_IDLE;
         rd_bank          <= 1'b0;
         ocnt             <= '0;
         olen             <= '0;
         axisif_start     <= 1'b0;
         axisif_frame_len <= '0;
         m_valid          <= 1'b0;
      end else begin
         axisif_start <= 1'b0;
         case (c_st)
            C_IDLE: begin
               if (full[rd_bank]) begin
                  c_st             <= C_START;
                  axisif_start     <= 1'b1;
                  axisif_frame_len <= bank_len[rd_bank];
               end
            end
            C_START: begin
               olen <= ((cfg_out_len == '0) || (cfg_out_len > OLW'(OUT_DATA_NUM)))
                       ? OLW'(OUT_DATA_NUM) : cfg_out_len;
               c_st <= C_BUSY;
            end
            C_BUSY: begin
               if (axisif_done) begin
                  c_st    <= C_TX;
                  m_valid <= 1'b1;
                  ocnt    <= '0;
               end
            end
            C_TX: begin
               if (m_ready) begin
                  if (tx_last) begin
                     m_valid          <= 1'b0;
                     rd_bank          <= ~rd_bank;
                     ocnt             <= '0;
                     axisif_frame_len <= '0;
                     c_st             <= C_IDLE;
                  end else begin
                     ocnt <= ocnt + 1'b1;
                  end
               end
            end
            default: c_st <= C_IDLE;
         endcase
      end
   end

`ifdef GPAXIS_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_short <= '0;
         err_cnt_long  <= '0;
      end else begin
         if (err_short && (err_cnt_short != 16'hFFFF))
            err_cnt_short <= err_cnt_short + 16'd1;
         if (err_long && (err_cnt_long != 16'hFFFF))
            err_cnt_long <= err_cnt_long + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gp_axis_dbuf_interface.sv
// Directed bench for gp_axis_dbuf_interface: table of frame shapes plus hand-written
// ping-pong stall and reset sequences; inputs change 1ns after posedge, outputs sampled at negedge.
module tb_gp_axis_dbuf_interface;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] s_data;
   logic        s_valid, s_last, s_ready;
   logic [31:0] m_data;
   logic        m_valid, m_last, m_ready;
   logic [3:0]  cfg_out_len;
   logic        axisif_start, axisif_done;
   logic [9:0]  axisif_frame_len;
   logic [9:0]  axisif_bufferIn_adr;
   logic [31:0] axisif_bufferIn_data;
   logic [3:0]  axisif_bufferOut_adr;
   logic [31:0] axisif_bufferOut_data;
   logic        axisif_bufferOut_wr;
   logic        err_short, err_long;
`ifdef GPAXIS_ERR_CNT_EN
   logic [15:0] err_cnt_short, err_cnt_long;
`endif

   gp_axis_dbuf_interface dut (
      .clk(clk), .rst_n(rst_n),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .cfg_out_len(cfg_out_len),
      .axisif_start(axisif_start), .axisif_done(axisif_done),
      .axisif_frame_len(axisif_frame_len),
      .axisif_bufferIn_adr(axisif_bufferIn_adr), .axisif_bufferIn_data(axisif_bufferIn_data),
      .axisif_bufferOut_adr(axisif_bufferOut_adr), .axisif_bufferOut_data(axisif_bufferOut_data),
      .axisif_bufferOut_wr(axisif_bufferOut_wr),
      .err_short(err_short), .err_long(err_long)
`ifdef GPAXIS_ERR_CNT_EN
      , .err_cnt_short(err_cnt_short), .err_cnt_long(err_cnt_long)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_es = 0, n_el = 0, n_st = 0;
   int stall_first, stall_total;
   time t_first, t_last_m;

   always @(negedge clk) begin
      if (err_short)    n_es++;
      if (err_long)     n_el++;
      if (axisif_start) n_st++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Beat k of a frame carries {tag, k}; last_at==0 means no s_last in the frame.
   task automatic send_frame(input int n, input int last_at, input logic [7:0] tag);
      int st;
      stall_total = 0;
      stall_first = 0;
      @(posedge clk); #1;
      for (int k = 0; k < n; k++) begin
         s_valid = 1'b1;
         s_data  = {tag, 24'(k)};
         s_last  = (k == last_at - 1);
         st = 0;
         @(negedge clk);
         while (!s_ready && st < 6000) begin
            @(negedge clk);
            st++;
         end
         if (st >= 6000) begin
            chk("s_ready_timeout", 32'(s_ready), 32'd1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
         end
         if (k == 0) begin
            stall_first = st;
            t_first     = $time;
         end
         stall_total += st;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Plays the core: waits for start, checks length and bank contents, writes results,
   // raises done after dly cycles, then drains the result stream.
   task automatic core_run(input int exp_len, input logic [3:0] cfg, input int mode,
                           input int dly, input logic [7:0] tag, input int exp_beats);
      int cnt, beat, cyc;
      int addrs[3];
      logic stalled;
      logic [31:0] pd;
      logic pl;
      cfg_out_len = cfg;
      cnt = 0;
      @(negedge clk);
      while (!axisif_start && cnt < 5000) begin
         @(negedge clk);
         cnt++;
      end
      chk("start_seen", 32'(axisif_start), 32'd1);
      if (cnt >= 5000) return;
      chk("frame_len", 32'(axisif_frame_len), 32'(exp_len));
      @(negedge clk);
      chk("start_one_cycle", 32'(axisif_start), 32'd0);
      addrs[0] = 0; addrs[1] = exp_len / 2; addrs[2] = exp_len - 1;
      for (int i = 0; i < 3; i++) begin
         axisif_bufferIn_adr = 10'(addrs[i]);
         #1;
         chk("bank_read", axisif_bufferIn_data, {tag, 24'(addrs[i])});
      end
      @(posedge clk); #1;
      for (int w = 0; w < 10; w++) begin
         axisif_bufferOut_adr  = 4'(w);
         axisif_bufferOut_data = {16'hA500, tag, 8'(w)};
         axisif_bufferOut_wr   = 1'b1;
         @(posedge clk); #1;
      end
      axisif_bufferOut_wr = 1'b0;
      repeat (dly) @(posedge clk);
      #1;
      axisif_done = 1'b1;
      @(posedge clk); #1;
      axisif_done = 1'b0;
      beat = 0; cyc = 0; stalled = 1'b0; pd = '0; pl = 1'b0;
      while (beat < exp_beats && cyc < 200) begin
         m_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         @(negedge clk);
         if (m_valid) begin
            if (stalled) begin
               chk("m_data_hold", m_data, pd);
               chk("m_last_hold", 32'(m_last), 32'(pl));
            end
            if (m_ready) begin
               chk("m_data", m_data, {16'hA500, tag, 8'(beat)});
               chk("m_last", 32'(m_last), 32'(beat == exp_beats - 1));
               if (beat == exp_beats - 1) t_last_m = $time;
               beat++;
               if (beat == 1) cfg_out_len = 4'd7;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               pd = m_data;
               pl = m_last;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      m_ready = 1'b0;
      chk("beat_count", 32'(beat), 32'(exp_beats));
      @(negedge clk);
      chk("m_valid_after_last", 32'(m_valid), 32'd0);
   endtask

   typedef struct {
      int n; int last_at; logic [3:0] cfg; int mode;
      int exp_len; int exp_short; int exp_long; int exp_beats;
   } vec_t;

   initial begin
      vec_t vt[5];
      int es0, el0, st0, s2_total, s3_first;
      time t_rel, t3_first;
      rst_n = 1'b0;
      s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
      cfg_out_len = 4'd10; axisif_done = 1'b0;
      axisif_bufferIn_adr = '0; axisif_bufferOut_adr = '0;
      axisif_bufferOut_data = '0; axisif_bufferOut_wr = 1'b0;

      //        n    last  cfg   mode len  short long beats
      vt[0] = '{784, 784, 4'd10, 0, 784, 0, 0, 10};
      vt[1] = '{100, 100, 4'd3,  1, 100, 1, 0, 3};
      vt[2] = '{790, 790, 4'd0,  0, 784, 0, 1, 10};
      vt[3] = '{1,   1,   4'd15, 1, 1,   1, 0, 10};
      vt[4] = '{783, 783, 4'd1,  0, 783, 1, 0, 1};

      #22;
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_last", 32'(m_last), 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_start", 32'(axisif_start), 0);
      chk("rst_frame_len", 32'(axisif_frame_len), 0);
      chk("rst_in_data", axisif_bufferIn_data, 0);
      chk("rst_err_short", 32'(err_short), 0);
      chk("rst_err_long", 32'(err_long), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("s_ready_after_rst", 32'(s_ready), 1);

      for (int i = 0; i < 5; i++) begin
         es0 = n_es; el0 = n_el; st0 = n_st;
         fork
            send_frame(vt[i].n, vt[i].last_at, 8'(8'h10 + i));
            core_run(vt[i].exp_len, vt[i].cfg, vt[i].mode, 3, 8'(8'h10 + i), vt[i].exp_beats);
         join
         chk($sformatf("v%0d_err_short", i), 32'(n_es - es0), 32'(vt[i].exp_short));
         chk($sformatf("v%0d_err_long", i), 32'(n_el - el0), 32'(vt[i].exp_long));
         chk($sformatf("v%0d_starts", i), 32'(n_st - st0), 32'd1);
      end

      // Ping-pong: frame 2 streams while frame 1 is held by the core; frame 3 must wait.
      s2_total = -1; s3_first = 0; t3_first = 0; t_rel = 0;
      fork
         begin
            send_frame(784, 784, 8'h21);
            send_frame(784, 784, 8'h22);
            s2_total = stall_total;
            send_frame(10, 10, 8'h23);
            s3_first = stall_first;
            t3_first = t_first;
         end
         begin
            core_run(784, 4'd10, 0, 2000, 8'h21, 10);
            t_rel = t_last_m;
            core_run(784, 4'd10, 0, 3, 8'h22, 10);
            core_run(10, 4'd2, 1, 3, 8'h23, 2);
         end
      join
      chk("pp_frame2_no_stall", 32'(s2_total), 0);
      chk("pp_frame3_stalled", 32'(s3_first > 0), 1);
      chk("pp_frame3_after_release", 32'(t3_first > t_rel), 1);

`ifdef GPAXIS_ERR_CNT_EN
      chk("cnt_short_total", 32'(err_cnt_short), 32'(n_es));
      chk("cnt_long_total", 32'(err_cnt_long), 32'(n_el));
`endif

      // Reset in the middle of a frame: nothing may be started for the partial frame.
      send_frame(50, 0, 8'h30);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midframe_rst_s_ready", 32'(s_ready), 0);
      chk("midframe_rst_start", 32'(axisif_start), 0);
      @(negedge clk);
      rst_n = 1'b1;
      st0 = n_st;
      repeat (20) @(negedge clk);
      chk("no_start_partial", 32'(n_st - st0), 0);

      // Reset while results are being streamed.
      fork
         send_frame(5, 5, 8'h31);
         begin
            int cnt = 0;
            @(negedge clk);
            while (!axisif_start && cnt < 200) begin
               @(negedge clk);
               cnt++;
            end
            chk("tx_rst_start_seen", 32'(axisif_start), 1);
            @(posedge clk); #1;
            axisif_done = 1'b1;
            @(posedge clk); #1;
            axisif_done = 1'b0;
            @(negedge clk);
            chk("tx_rst_m_valid_before", 32'(m_valid), 1);
            #2;
            rst_n = 1'b0;
            #1;
            chk("tx_rst_m_valid", 32'(m_valid), 0);
            chk("tx_rst_m_data", m_data, 0);
            chk("tx_rst_frame_len", 32'(axisif_frame_len), 0);
            chk("tx_rst_s_ready", 32'(s_ready), 0);
`ifdef GPAXIS_ERR_CNT_EN
            chk("tx_rst_cnt_short", 32'(err_cnt_short), 0);
            chk("tx_rst_cnt_long", 32'(err_cnt_long), 0);
`endif
            @(negedge clk);
            rst_n = 1'b1;
         end
      join

      fork
         send_frame(784, 784, 8'h41);
         core_run(784, 4'd10, 0, 3, 8'h41, 10);
      join

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gp_axis_dbuf_interface.md
Name: gp_axis_dbuf_interface

Overview:
- Generalised successor to the single-buffer AXI-Stream wrapper between the DMA and a CNN layer core.
- Ping-pong (two-bank) input buffer: frame N+1 is received while the core processes frame N.
- Supports variable-length frames delimited by s_last, with short/long frame error detection.
- Output beat count is runtime-configurable. Output buffer is single-bank; the core owns it between axisif_start and axisif_done.

Parameters:
- DATA_WIDTH, 32, width of stream data and buffer words.
- IN_DATA_NUM, 784, words per input bank (max frame length).
- OUT_DATA_NUM, 10, words in output buffer (max result length).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  DATA_WIDTH  slave stream data.
- s_valid  in  1  slave valid.
- s_last  in  1  slave end-of-frame.
- s_ready  out  1  slave ready.
- m_data  out  DATA_WIDTH  master stream data.
- m_valid  out  1  master valid.
- m_last  out  1  master end-of-frame.
- m_ready  in  1  master ready.
- cfg_out_len  in  clog2(OUT_DATA_NUM+1)  result beats per frame, 1..OUT_DATA_NUM; sampled at start.
- axisif_start  out  1  one-cycle pulse: input bank ready for the core.
- axisif_done  in  1  core finished and output buffer written.
- axisif_frame_len  out  clog2(IN_DATA_NUM+1)  words received in the bank being processed; stable from start until the bank is released.
- axisif_bufferIn_adr  in  clog2(IN_DATA_NUM)  core read address.
- axisif_bufferIn_data  out  DATA_WIDTH  combinational read of the processing bank.
- axisif_bufferOut_adr  in  clog2(OUT_DATA_NUM)  core write address.
- axisif_bufferOut_data  in  DATA_WIDTH  core write data.
- axisif_bufferOut_wr  in  1  core write enable; honoured only in C_BUSY.
- err_short  out  1  one-cycle pulse: s_last before IN_DATA_NUM words.
- err_long  out  1  one-cycle pulse: IN_DATA_NUM words accepted without s_last.

Behaviour:
- Reset (asynchronous): all outputs 0; both banks empty; wr_bank=0, rd_bank=0; counters 0; RX FSM=RX_FILL; core FSM=C_IDLE. Buffer contents are not reset.
- RX FSM states: RX_FILL, RX_WAIT, RX_DROP.
  - RX_FILL: s_ready = bank[wr_bank] empty. On handshake, write bank[wr_bank][wcnt]; wcnt++.
  - Frame closes on a handshake with s_last, or when wcnt==IN_DATA_NUM-1.
  - On close: mark bank full, store length=wcnt+1, toggle wr_bank, wcnt=0.
  - Early s_last (wcnt<IN_DATA_NUM-1): also pulse err_short the next cycle.
  - wcnt==IN_DATA_NUM-1 with s_last=0: also pulse err_long and go to RX_DROP.
  - RX_WAIT: entered when a frame closes and the next bank is full; s_ready=0. Return to RX_FILL the cycle after that bank is released.
  - RX_DROP: s_ready=1; beats are discarded without writes until a handshake with s_last. Then go to RX_FILL, or to RX_WAIT if the next bank is full.
- Core FSM states: C_IDLE, C_START, C_BUSY, C_TX.
  - C_IDLE: if bank[rd_bank] full, go to C_START.
  - C_START: axisif_start=1 for exactly one cycle; latch cfg_out_len (0 or >OUT_DATA_NUM clamps to OUT_DATA_NUM); go to C_BUSY.
  - C_BUSY: wait for axisif_done; done is ignored in any other state.
  - C_TX: m_valid=1; m_data=out[ocnt] (combinational). ocnt advances on m_valid&m_ready. m_last=1 while ocnt==len-1, with no dependence on m_ready. m_data/m_last held stable while m_ready=0.
  - On the final handshake: clear full of rd_bank, toggle rd_bank, ocnt=0, go to C_IDLE.
- Minimum gap: 1 idle cycle between the last m beat and the next axisif_start.
- Simultaneous events:
  - RX closing bank X in the same cycle core releases bank Y: both take effect; no beat is lost.
  - Reset mid-frame: partial frame discarded; no start is issued for it.
- Throughput: one beat per cycle on both sides; the slave side never stalls while the other bank is empty.

Optional Feature:
- Macro GPAXIS_ERR_CNT_EN.
- When defined:
  - Adds outputs err_cnt_short and err_cnt_long, 16 bits each, saturating at 0xFFFF.
  - Each increments on the matching err pulse; cleared only by rst_n.
- When undefined: ports and logic absent; err_short and err_long pulses unchanged.

Test Plan:
- Defaults, 784-beat frame with s_last on beat 784 -> one axisif_start; axisif_frame_len=784; core reads word k==s_data of beat k; after done, 10 m beats; m_last only on beat 10; no err.
- Two back-to-back frames, core holds done low 2000 cycles -> frame 2 fully accepted with no stall; frame 3's first beat sees s_ready=0 until frame 1 output finishes.
- 100-beat frame with s_last on beat 100 -> err_short pulse; axisif_frame_len=100; processing proceeds normally.
- 790-beat frame, s_last on beat 790 -> err_long after beat 784; beats 785-790 accepted and dropped; next frame lands intact in the other bank.
- cfg_out_len=3, m_ready toggling 1,0,0,1,... -> exactly 3 beats; data stable during stalls; m_last on beat 3. cfg_out_len changed mid-C_TX has no effect.
- rst_n low mid-frame and during C_TX -> all outputs 0 immediately; next full frame processed correctly from bank 0; with GPAXIS_ERR_CNT_EN, counters read 0.
